// File: rtl/mem_req_pmp_buf.sv
// mem_req_pmp_buf
// Request-side stage in front of the RAM block. Each incoming request
// {addr, data, wr} is checked against NUM_REGIONS TOR-style PMP entries.
// Permitted requests are pushed into a DEPTH-entry FIFO that drains to the
// RAM port. Denied writes are dropped and reported through an error pulse,
// a last-denied-address register and a saturating error counter.
//
// Ports
//   clk_i, rst_ni            clock (rising edge), async active-low reset
//   req_valid_i/req_ready_o  upstream handshake
//   req_addr_i/data_i/wr_i   upstream request payload
//   pmp_lock_i               per-entry lock bit
//   pmp_mode_i               per-entry mode, entry i at [2i+1:2i], 2'b01 = TOR
//   pmp_addr_i               per-entry exclusive top, entry i at [AW*i +: AW]
//   mem_valid_o/mem_ready_i  RAM-side handshake
//   mem_addr/data/wr_o       FIFO head entry (zero while empty)
//   err_valid_o              one-cycle pulse per denied request
//   err_addr_o               address of the most recent denial
//   err_cnt_o                saturating count of denials
//   count_o                  FIFO occupancy, 0..DEPTH
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Valid never depends on ready of the same interface; a producer
// holding valid keeps its payload stable until the transfer.
module mem_req_pmp_buf #(
    parameter int DEPTH       = 4,
    parameter int AW          = 8,
    parameter int DW          = 8,
    parameter int NUM_REGIONS = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [AW-1:0]             req_addr_i,
    input  logic [DW-1:0]             req_data_i,
    input  logic                      req_wr_i,
    input  logic [NUM_REGIONS-1:0]    pmp_lock_i,
    input  logic [2*NUM_REGIONS-1:0]  pmp_mode_i,
    input  logic [AW*NUM_REGIONS-1:0] pmp_addr_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output logic [AW-1:0]             mem_addr_o,
    output logic [DW-1:0]             mem_data_o,
    output logic                      mem_wr_o,
    output logic                      err_valid_o,
    output logic [AW-1:0]             err_addr_o,
    output logic [7:0]                err_cnt_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic          wr_mem   [DEPTH];

    logic [PW-1:0] wptr_q, rptr_q;
    logic [PW:0]   count_q;

    logic          pmp_hit, pmp_hit_lock;
    logic [AW-1:0] lo, top;
    logic          accept, deny, push, pop;

    // TOR match: entry i covers [top of entry i-1, top of entry i). The lower
    // bound follows the previous entry's top whatever that entry's mode is.
    // Only the lowest-index matching entry decides.
    always_comb begin
        pmp_hit      = 1'b0;
        pmp_hit_lock = 1'b0;
        lo           = '0;
        top          = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            top = pmp_addr_i[AW*i +: AW];
            if (!pmp_hit && (pmp_mode_i[2*i +: 2] == 2'b01) &&
                (req_addr_i >= lo) && (req_addr_i < top)) begin
                pmp_hit      = 1'b1;
                pmp_hit_lock = pmp_lock_i[i];
            end
            lo = top;
        end
    end

    // Ready comes from the registered occupancy only, so a full FIFO stays
    // unready even in a cycle where the head is being popped.
    assign req_ready_o = (count_q != FULL_CNT);
    assign accept      = req_valid_i & req_ready_o;
    assign deny        = accept & req_wr_i & pmp_hit & pmp_hit_lock;
    assign push        = accept & ~deny;
    assign mem_valid_o = (count_q != '0);
    assign pop         = mem_valid_o & mem_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the head is gated to zero while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wptr_q] <= req_addr_i;
            data_mem[wptr_q] <= req_data_i;
            wr_mem[wptr_q]   <= req_wr_i;
        end
    end

    assign mem_addr_o = mem_valid_o ? addr_mem[rptr_q] : '0;
    assign mem_data_o = mem_valid_o ? data_mem[rptr_q] : '0;
    assign mem_wr_o   = mem_valid_o ? wr_mem[rptr_q]   : 1'b0;
    assign count_o    = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_valid_o <= 1'b0;
            err_addr_o  <= '0;
            err_cnt_o   <= '0;
        end else begin
            err_valid_o <= deny;
            if (deny) begin
                err_addr_o <= req_addr_i;
                if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_req_pmp_buf.sv
// Directed bench for mem_req_pmp_buf (DEPTH=4, AW=DW=8, NUM_REGIONS=2).
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_mem_req_pmp_buf;
    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [7:0] req_addr_i = '0;
    logic [7:0] req_data_i = '0;
    logic       req_wr_i = 1'b0;
    logic [1:0] pmp_lock_i = '0;
    logic [3:0] pmp_mode_i = '0;
    logic [15:0] pmp_addr_i = '0;
    logic       mem_valid_o;
    logic       mem_ready_i = 1'b0;
    logic [7:0] mem_addr_o;
    logic [7:0] mem_data_o;
    logic       mem_wr_o;
    logic       err_valid_o;
    logic [7:0] err_addr_o;
    logic [7:0] err_cnt_o;
    logic [2:0] count_o;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    mem_req_pmp_buf #(.DEPTH(4), .AW(8), .DW(8), .NUM_REGIONS(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_wr_i(req_wr_i),
        .pmp_lock_i(pmp_lock_i), .pmp_mode_i(pmp_mode_i), .pmp_addr_i(pmp_addr_i),
        .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_wr_o(mem_wr_o),
        .err_valid_o(err_valid_o), .err_addr_o(err_addr_o), .err_cnt_o(err_cnt_o),
        .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle request; caller guarantees req_ready_o is high.
    task automatic send(input logic [7:0] a, input logic [7:0] d, input logic w);
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_data_i  = d;
        req_wr_i    = w;
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid_o); end
        checks++; if (mem_addr_o !== 8'h00) begin errors++; $display("FAIL reset_mem_addr got=%h exp=00", mem_addr_o); end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL reset_err_valid got=%b exp=0", err_valid_o); end
        checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt_o); end
        checks++; if (err_addr_o !== 8'h00) begin errors++; $display("FAIL reset_err_addr got=%h exp=00", err_addr_o); end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", req_ready_o); end
        step();
    endtask

    task automatic test_reads();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(8'h10 + 8'(i), 8'hA0 + 8'(i), 1'b0);
            checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 8'h10 + 8'(i)) begin
                errors++; $display("FAIL reads_head i=%0d got=%b/%h exp=1/%h", i, mem_valid_o, mem_addr_o, 8'h10 + 8'(i));
            end
            checks++; if (mem_data_o !== 8'hA0 + 8'(i) || mem_wr_o !== 1'b0) begin
                errors++; $display("FAIL reads_data i=%0d got=%h/%b exp=%h/0", i, mem_data_o, mem_wr_o, 8'hA0 + 8'(i));
            end
            checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL reads_err i=%0d got=%b exp=0", i, err_valid_o); end
        end
        step();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL reads_drain got=%0d exp=0", count_o); end
    endtask

    task automatic test_pmp_lock();
        pmp_mode_i = 4'b00_01;
        pmp_addr_i = {8'h00, 8'h40};
        pmp_lock_i = 2'b01;
        mem_ready_i = 1'b1;
        send(8'h20, 8'h55, 1'b1);
        checks++; if (mem_valid_o !== 1'b0) begin errors++; $display("FAIL lock_wr_fwd got=%b exp=0", mem_valid_o); end
        checks++; if (err_valid_o !== 1'b1) begin errors++; $display("FAIL lock_err_pulse got=%b exp=1", err_valid_o); end
        checks++; if (err_addr_o !== 8'h20) begin errors++; $display("FAIL lock_err_addr got=%h exp=20", err_addr_o); end
        checks++; if (err_cnt_o !== 8'd1) begin errors++; $display("FAIL lock_err_cnt got=%0d exp=1", err_cnt_o); end
        step();
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL lock_err_once got=%b exp=0", err_valid_o); end
        checks++; if (err_addr_o !== 8'h20) begin errors++; $display("FAIL lock_err_hold got=%h exp=20", err_addr_o); end
        send(8'h20, 8'h66, 1'b0);
        checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 8'h20 || mem_wr_o !== 1'b0) begin
            errors++; $display("FAIL lock_rd_fwd got=%b/%h/%b exp=1/20/0", mem_valid_o, mem_addr_o, mem_wr_o);
        end
        checks++; if (err_valid_o !== 1'b0) begin errors++; $display("FAIL lock_rd_err got=%b exp=0", err_valid_o); end
        step();
    endtask

    task automatic test_pmp_tor();
        pmp_mode_i = 4'b01_01;
        pmp_addr_i = {8'h80, 8'h40};
        pmp_lock_i = 2'b10;
        mem_ready_i = 1'b1;
        send(8'h3F, 8'h11, 1'b1);
        checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 8'h3F || mem_wr_o !== 1'b1 || mem_data_o !== 8'h11) begin
            errors++; $display("FAIL tor_3f got=%b/%h/%b/%h exp=1/3f/1/11", mem_valid_o, mem_addr_o, mem_wr_o, mem_data_o);
        end
        send(8'h40, 8'h22, 1'b1);
        checks++; if (mem_valid_o !== 1'b0 || err_valid_o !== 1'b1) begin
            errors++; $display("FAIL tor_40_deny got=mv%b/ev%b exp=mv0/ev1", mem_valid_o, err_valid_o);
        end
        checks++; if (err_addr_o !== 8'h40 || err_cnt_o !== 8'd2) begin
            errors++; $display("FAIL tor_40_err got=%h/%0d exp=40/2", err_addr_o, err_cnt_o);
        end
        send(8'h80, 8'h33, 1'b1);
        checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 8'h80 || err_valid_o !== 1'b0) begin
            errors++; $display("FAIL tor_80 got=%b/%h/ev%b exp=1/80/ev0", mem_valid_o, mem_addr_o, err_valid_o);
        end
        send(8'h50, 8'h44, 1'b0);
        checks++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 8'h50 || err_cnt_o !== 8'd2) begin
            errors++; $display("FAIL tor_rd50 got=%b/%h/%0d exp=1/50/2", mem_valid_o, mem_addr_o, err_cnt_o);
        end
        step();
    endtask

    task automatic test_full();
        pmp_mode_i = 4'b00_00;
        mem_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 8'hC0 + 8'(i), 1'b0);
        checks++; if (count_o !== 3'd4 || req_ready_o !== 1'b0) begin
            errors++; $display("FAIL full_count got=%0d/rdy%b exp=4/rdy0", count_o, req_ready_o);
        end
        req_valid_i = 1'b1; req_addr_i = 8'h64; req_data_i = 8'hC4; req_wr_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (count_o !== 3'd4 || req_ready_o !== 1'b0 || mem_addr_o !== 8'h60 || mem_data_o !== 8'hC0) begin
                errors++; $display("FAIL full_stall i=%0d got=%0d/rdy%b/%h/%h exp=4/rdy0/60/c0", i, count_o, req_ready_o, mem_addr_o, mem_data_o);
            end
        end
        mem_ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL full_no_bypass got=%b exp=0", req_ready_o); end
        step();
        checks++; if (count_o !== 3'd3 || req_ready_o !== 1'b1 || mem_addr_o !== 8'h61) begin
            errors++; $display("FAIL full_first_pop got=%0d/rdy%b/%h exp=3/rdy1/61", count_o, req_ready_o, mem_addr_o);
        end
        step();
        req_valid_i = 1'b0;
        checks++; if (count_o !== 3'd3 || mem_addr_o !== 8'h62) begin
            errors++; $display("FAIL full_fifth_in got=%0d/%h exp=3/62", count_o, mem_addr_o);
        end
        exp_q.push_back(8'h62); exp_q.push_back(8'h63); exp_q.push_back(8'h64);
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            if (mem_valid_o) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checks++; if (mem_addr_o !== e) begin errors++; $display("FAIL full_order got=%h exp=%h", mem_addr_o, e); end
            end
            step();
        end
        checks++; if (exp_q.size() != 0 || count_o !== 3'd0) begin
            errors++; $display("FAIL full_drain left=%0d count=%0d exp=0/0", exp_q.size(), count_o);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        mem_ready_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [7:0] a;
            a = 8'(i * 13);
            send(a, ~a, i[0]);
            checks++; if (count_o !== 3'd1 || mem_addr_o !== a || mem_data_o !== ~a || mem_wr_o !== i[0]) begin
                errors++; $display("FAIL stream i=%0d got=%0d/%h/%h/%b exp=1/%h/%h/%b", i, count_o, mem_addr_o, mem_data_o, mem_wr_o, a, ~a, i[0]);
            end
        end
        step();
        checks++; if (count_o !== 3'd0) begin errors++; $display("FAIL stream_drain got=%0d exp=0", count_o); end
    endtask

    task automatic test_reset_mid();
        mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(8'h90 + 8'(i), 8'h00, 1'b0);
        checks++; if (count_o !== 3'd3) begin errors++; $display("FAIL rstmid_load got=%0d exp=3", count_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        checks++; if (mem_valid_o !== 1'b0 || count_o !== 3'd0 || mem_addr_o !== 8'h00) begin
            errors++; $display("FAIL rstmid_async got=%b/%0d/%h exp=0/0/00", mem_valid_o, count_o, mem_addr_o);
        end
        checks++; if (err_cnt_o !== 8'd0) begin errors++; $display("FAIL rstmid_errcnt got=%0d exp=0", err_cnt_o); end
        step();
        rst_ni = 1'b1;
        mem_ready_i = 1'b1;
        step();
        checks++; if (mem_valid_o !== 1'b0 || count_o !== 3'd0) begin
            errors++; $display("FAIL rstmid_release got=%b/%0d exp=0/0", mem_valid_o, count_o);
        end
    endtask

    task automatic test_saturation();
        pmp_mode_i = 4'b00_01;
        pmp_addr_i = {8'h00, 8'hFF};
        pmp_lock_i = 2'b01;
        req_valid_i = 1'b1; req_addr_i = 8'h05; req_data_i = 8'h00; req_wr_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 0 || i == 1 || i == 254 || i == 255 || i == 299) begin
                logic [7:0] e;
                e = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
                checks++; if (err_cnt_o !== e || err_valid_o !== 1'b1) begin
                    errors++; $display("FAIL sat i=%0d got=%0d/ev%b exp=%0d/ev1", i, err_cnt_o, err_valid_o, e);
                end
            end
        end
        req_valid_i = 1'b0;
        step();
        checks++; if (err_valid_o !== 1'b0 || count_o !== 3'd0 || err_addr_o !== 8'h05) begin
            errors++; $display("FAIL sat_end got=ev%b/%0d/%h exp=ev0/0/05", err_valid_o, count_o, err_addr_o);
        end
    endtask

    initial begin
        test_reset();
        test_reads();
        test_pmp_lock();
        test_pmp_tor();
        test_full();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
